// File: rtl/gpr_file_sb_pkg.sv
// Shared defaults, zero constants and packed-port slice macros for the GPR file.
// Declarations only: no logic, no latency, no backpressure.
`ifndef GPR_FILE_SB_DEFINES
`define GPR_FILE_SB_DEFINES
`define X0        0
`define ZeroWord  '0
`define GPR_XLEN  32
`define GPR_NREG  32
`define GPR_NRD   2
`define GPR_NWR   2
`define SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package gpr_file_sb_pkg;
    localparam int DEF_XLEN = `GPR_XLEN;
    localparam int DEF_NREG = `GPR_NREG;
    localparam int DEF_NRD  = `GPR_NRD;
    localparam int DEF_NWR  = `GPR_NWR;
endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits (Flush > Issue > writeback clear); RdBusy is combinational
// and unmasked, busy state updates at posedge; no backpressure.
module gpr_scoreboard
    import gpr_file_sb_pkg::*;
#(
    parameter  int NREG = DEF_NREG,
    parameter  int NRD  = DEF_NRD,
    parameter  int NWR  = DEF_NWR,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [NRD*AW-1:0] RdAddr,
    input  logic [NWR-1:0]    WrEn,
    input  logic [NWR*AW-1:0] WrAddr,
    input  logic            IssueEn,
    input  logic [AW-1:0]   IssueRd,
    input  logic            Flush,
    output logic [NRD-1:0]  RdBusy
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Issue is applied after the writeback clears so a new producer stays outstanding.
    always_comb begin
        busy_nxt = busy;
        if (Flush) begin
            busy_nxt = '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (WrEn[w]) begin
                    busy_nxt[`SLICE(WrAddr, w, AW)] = 1'b0;
                end
            end
            if (IssueEn) begin
                busy_nxt[IssueRd] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_comb begin
        RdBusy = '0;
        for (int i = 0; i < NRD; i++) begin
            RdBusy[i] = busy[`SLICE(RdAddr, i, AW)];
        end
    end

endmodule

// File: rtl/gpr_file_sb.sv
// Multi-port register file with write-to-read bypass, busy scoreboard and debug port.
// Reads are zero-latency, debug read is 1 cycle; no backpressure.
module gpr_file_sb
    import gpr_file_sb_pkg::*;
#(
    parameter  int XLEN   = DEF_XLEN,
    parameter  int NREG   = DEF_NREG,
    parameter  int NRD    = DEF_NRD,
    parameter  int NWR    = DEF_NWR,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [NRD*AW-1:0]   RdAddr,
    output logic [NRD*XLEN-1:0] RdData,
    output logic [NRD-1:0]      RdBusy,
    input  logic [NWR-1:0]      WrEn,
    input  logic [NWR*AW-1:0]   WrAddr,
    input  logic [NWR*XLEN-1:0] WrData,
    input  logic                IssueEn,
    input  logic [AW-1:0]       IssueRd,
    input  logic                Flush,
    input  logic [AW-1:0]       DbgAddr,
    output logic [XLEN-1:0]     DbgData
);

    logic [XLEN-1:0] regs [NREG];
    logic [NRD-1:0]  busy_raw;
    logic [NRD-1:0]  fwd_hit;

    gpr_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR)
    ) u_sb (
        .Clk     (Clk),
        .Rst     (Rst),
        .RdAddr  (RdAddr),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .IssueEn (IssueEn),
        .IssueRd (IssueRd),
        .Flush   (Flush),
        .RdBusy  (busy_raw)
    );

    // Ascending loop: the last (highest-index) enabled port to an address wins.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= `ZeroWord;
            end
            DbgData <= `ZeroWord;
        end else begin
            DbgData <= regs[DbgAddr];
            for (int w = 0; w < NWR; w++) begin
                if (WrEn[w] && `SLICE(WrAddr, w, AW) != AW'(`X0)) begin
                    regs[`SLICE(WrAddr, w, AW)] <= `SLICE(WrData, w, XLEN);
                end
            end
        end
    end

    always_comb begin
        RdData  = '0;
        fwd_hit = '0;
        for (int i = 0; i < NRD; i++) begin
            `SLICE(RdData, i, XLEN) = regs[`SLICE(RdAddr, i, AW)];
            for (int w = 0; w < NWR; w++) begin
                if (BYPASS != 0 && !Rst && WrEn[w] &&
                    `SLICE(WrAddr, w, AW) == `SLICE(RdAddr, i, AW)) begin
                    `SLICE(RdData, i, XLEN) = `SLICE(WrData, w, XLEN);
                    fwd_hit[i] = 1'b1;
                end
            end
            if (`SLICE(RdAddr, i, AW) == AW'(`X0)) begin
                `SLICE(RdData, i, XLEN) = `ZeroWord;
                fwd_hit[i] = 1'b0;
            end
        end
    end

    // Forwarded data is current, so the reader need not stall on it.
    assign RdBusy = busy_raw & ~fwd_hit;

endmodule

// File: tb/tb_gpr_file_sb.sv
// Scoreboard bench: bypass and non-bypass instances share stimulus; a reference
// model pushes expected outputs per cycle and a negedge monitor pops and compares.
module tb_gpr_file_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                Clk = 1'b0;
    logic                Rst;
    logic [NRD*AW-1:0]   RdAddr;
    logic [NWR-1:0]      WrEn;
    logic [NWR*AW-1:0]   WrAddr;
    logic [NWR*XLEN-1:0] WrData;
    logic                IssueEn;
    logic [AW-1:0]       IssueRd;
    logic                Flush;
    logic [AW-1:0]       DbgAddr;

    logic [NRD*XLEN-1:0] rd_b1, rd_b0;
    logic [NRD-1:0]      bz_b1, bz_b0;
    logic [XLEN-1:0]     dbg_b1, dbg_b0;

    gpr_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
        .Clk(Clk), .Rst(Rst), .RdAddr(RdAddr), .RdData(rd_b1), .RdBusy(bz_b1),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .IssueEn(IssueEn),
        .IssueRd(IssueRd), .Flush(Flush), .DbgAddr(DbgAddr), .DbgData(dbg_b1));

    gpr_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
        .Clk(Clk), .Rst(Rst), .RdAddr(RdAddr), .RdData(rd_b0), .RdBusy(bz_b0),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .IssueEn(IssueEn),
        .IssueRd(IssueRd), .Flush(Flush), .DbgAddr(DbgAddr), .DbgData(dbg_b0));

    always #5 Clk = ~Clk;

    typedef struct {
        logic [NRD*XLEN-1:0] rd1;
        logic [NRD*XLEN-1:0] rd0;
        logic [NRD-1:0]      bz1;
        logic [NRD-1:0]      bz0;
        logic [XLEN-1:0]     dbg;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [XLEN-1:0] mem [NREG];
    logic            busy_m [NREG];
    logic [XLEN-1:0] dbg_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            e_mon = q.pop_front();
            check("rd_bypass",   64'(rd_b1),  64'(e_mon.rd1));
            check("rd_nobypass", 64'(rd_b0),  64'(e_mon.rd0));
            check("busy_bypass", 64'(bz_b1),  64'(e_mon.bz1));
            check("busy_nobyp",  64'(bz_b0),  64'(e_mon.bz0));
            check("dbg_bypass",  64'(dbg_b1), 64'(e_mon.dbg));
            check("dbg_nobyp",   64'(dbg_b0), 64'(e_mon.dbg));
        end
    end

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            mem[r]    = '0;
            busy_m[r] = 1'b0;
        end
        dbg_m = '0;
    endtask

    // Port i's view: newest same-cycle write (highest port) if forwarding, else storage.
    task automatic model_read(input bit bp, input int i, output logic [XLEN-1:0] d, output logic b);
        logic [AW-1:0] a;
        bit found;
        a = RdAddr[i*AW +: AW];
        d = mem[a];
        b = busy_m[a];
        found = 1'b0;
        if (bp && !Rst) begin
            for (int w = NWR - 1; w >= 0; w--) begin
                if (!found && WrEn[w] && WrAddr[w*AW +: AW] == a) begin
                    d = WrData[w*XLEN +: XLEN];
                    b = 1'b0;
                    found = 1'b1;
                end
            end
        end
        if (a == 0 || Rst) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [AW-1:0] a;
        bit taken [NREG];
        dbg_m = mem[DbgAddr];
        for (int r = 0; r < NREG; r++) taken[r] = 1'b0;
        for (int w = NWR - 1; w >= 0; w--) begin
            a = WrAddr[w*AW +: AW];
            if (WrEn[w] && a != 0 && !taken[a]) begin
                mem[a]   = WrData[w*XLEN +: XLEN];
                taken[a] = 1'b1;
            end
        end
        if (Flush) begin
            for (int r = 0; r < NREG; r++) busy_m[r] = 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) if (taken[r]) busy_m[r] = 1'b0;
            if (IssueEn && IssueRd != 0) busy_m[IssueRd] = 1'b1;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        logic [XLEN-1:0] d;
        logic b;
        for (int i = 0; i < NRD; i++) begin
            model_read(1'b1, i, d, b);
            e.rd1[i*XLEN +: XLEN] = d;
            e.bz1[i] = b;
            model_read(1'b0, i, d, b);
            e.rd0[i*XLEN +: XLEN] = d;
            e.bz0[i] = b;
        end
        e.dbg = Rst ? '0 : dbg_m;
        q.push_back(e);
    endtask

    task automatic step();
        if (Rst) model_reset();
        push_expect();
        @(posedge Clk);
        if (Rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic idle();
        Rst = 1'b0; WrEn = '0; IssueEn = 1'b0; Flush = 1'b0;
    endtask

    task automatic set_wr(input int w, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        WrEn[w] = 1'b1;
        WrAddr[w*AW +: AW] = a;
        WrData[w*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        RdAddr[i*AW +: AW] = a;
    endtask

    task automatic issue(input logic [AW-1:0] r);
        IssueEn = 1'b1;
        IssueRd = r;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
    endfunction

    task automatic rand_inputs();
        WrEn    = NWR'($urandom_range(0, 3));
        for (int w = 0; w < NWR; w++) begin
            WrAddr[w*AW +: AW]     = rand_addr();
            WrData[w*XLEN +: XLEN] = $urandom;
        end
        for (int i = 0; i < NRD; i++) RdAddr[i*AW +: AW] = rand_addr();
        IssueEn = ($urandom_range(0, 1) != 0);
        IssueRd = rand_addr();
        Flush   = ($urandom_range(0, 15) == 0);
        DbgAddr = rand_addr();
        Rst     = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        WrAddr = '0; WrData = '0; RdAddr = '0; IssueRd = '0; DbgAddr = '0;
        idle();
        Rst = 1'b1;
        model_reset();
        @(posedge Clk); #1;
        step();
        idle(); step();

        // Write x5, then async reset while it is being read
        set_wr(0, 5'd5, 32'h1234); set_rd(0, 5'd5); DbgAddr = 5'd5; issue(5'd6); set_rd(1, 5'd6); step();
        idle(); step();
        Rst = 1'b1; step();
        idle(); step();

        // Two ports on x7: port 1 wins, forwarded and stored
        set_wr(0, 5'd7, 32'hAAAA0000); set_wr(1, 5'd7, 32'h5555FFFF); set_rd(0, 5'd7); DbgAddr = 5'd7; step();
        idle(); step();
        step();

        // x3 write: non-bypass sees old value this cycle
        set_wr(0, 5'd3, 32'hDEADBEEF); set_rd(0, 5'd3); step();
        idle(); step();

        // x0 is never written, never busy
        set_wr(1, 5'd0, 32'hFFFFFFFF); issue(5'd0); set_rd(0, 5'd0); set_rd(1, 5'd0); DbgAddr = 5'd0; step();
        idle(); step();
        step();

        // Issue beats same-cycle writeback; plain writeback clears
        issue(5'd9); set_rd(0, 5'd9); step();
        idle(); step();
        issue(5'd9); set_wr(0, 5'd9, 32'h11112222); step();
        idle(); step();
        set_wr(0, 5'd9, 32'h33334444); step();
        idle(); step();

        // Flush drops the concurrent issue
        issue(5'd4); set_rd(0, 5'd4); set_rd(1, 5'd8); step();
        issue(5'd8); step();
        issue(5'd12); step();
        idle(); step();
        Flush = 1'b1; issue(5'd15); set_rd(0, 5'd15); set_rd(1, 5'd12); step();
        idle(); step();
        set_rd(0, 5'd4); set_rd(1, 5'd8); step();

        repeat (400) begin
            rand_inputs();
            step();
        end

        idle(); step();
        @(negedge Clk); #1;
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
Parametrised general-purpose register file for the RV core. It is the next generation of the 2R/1W register file.
- Configurable data width, register count, read-port count and write-port count.
- Write-to-read bypass.
- Asynchronous reset of all registers.
- Per-register busy scoreboard, used by the decode stage for RAW hazard detection.
- Registered debug read port.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of registers (power of 2); index 0 is hardwired zero
AW, $clog2(NREG), address width (derived localparam, not overridable)
NRD, 2, number of combinational read ports
NWR, 2, number of write ports; higher index has higher priority
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value

Ports:
Clk  in  1  core clock, posedge
Rst  in  1  asynchronous active-high reset
RdAddr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW]
RdData  out  NRD*XLEN  packed read data
RdBusy  out  NRD  busy flag of each read port's register
WrEn  in  NWR  write enables
WrAddr  in  NWR*AW  packed write addresses
WrData  in  NWR*XLEN  packed write data
IssueEn  in  1  decode issued an instruction that writes IssueRd
IssueRd  in  AW  destination register being issued
Flush  in  1  clears every busy bit (pipeline flush)
DbgAddr  in  AW  debug read address
DbgData  out  XLEN  debug read data, registered

Behaviour:
- Reset (Rst=1, async):
  - All registers become 0; all busy bits become 0; DbgData becomes 0.
  - RdData therefore reads 0 and RdBusy reads 0 while reset is held.
  - Inputs are ignored until the first posedge after deassertion.
- Register 0:
  - Reads as 0 on every port, including with bypass.
  - Never busy; writes and issues to it are discarded.
- Write (posedge Clk):
  - For each port with WrEn=1 and WrAddr!=0, the register takes WrData.
  - Two or more ports writing the same address in one cycle: the highest-index enabled port wins. No error flag.
- Read:
  - Combinational, zero latency.
  - BYPASS=1 and some enabled write port targets RdAddr!=0 this cycle: RdData is that port's WrData (same priority rule). Otherwise RdData is the stored value.
  - BYPASS=0: RdData is always the stored value; new data is visible the cycle after the write.
- Scoreboard, one busy bit per register, updated at posedge. Priority, highest first:
  1. Flush=1: all bits cleared; IssueEn in the same cycle is dropped.
  2. IssueEn=1 and IssueRd!=0: busy[IssueRd] set. This wins over a same-cycle writeback to the same register, because the new producer is outstanding.
  3. Any WrEn=1 to register r (r not matched by step 2): busy[r] cleared.
- RdBusy[i]:
  - Equals busy[RdAddr_i].
  - When BYPASS=1, forced to 0 if an enabled write port targets RdAddr_i this cycle, since the data is being forwarded.
  - Always 0 for register 0.
- Debug port: DbgData <= value of register DbgAddr at each posedge, pre-write (stored value, no bypass). Latency 1 cycle; register 0 returns 0.
- Reset mid-operation: pending writes and issues in that cycle are lost; the state is fully cleared.
- No X propagation: every output is defined for every input combination once reset has been applied.

Decomposition:
- Shared defines file: X0 and ZeroWord (existing), plus new macros for the default XLEN, NREG and port counts.
- Packed-slice helper macros for the port vectors.
- Sub-module gpr_scoreboard:
  - Contains the busy vector, the Flush/Issue/Write priority logic, and the RdBusy generation without bypass.
  - The parent applies the bypass masking.
- The data array, write-priority mux, bypass mux and debug register stay in gpr_file_sb.

Test Plan:
1. Rst pulse mid-cycle after writing x5=0x1234 -> RdData for x5 is 0 immediately (async), RdBusy all 0, DbgData=0.
2. WrEn=2'b11, both ports write x7 (port0=0xAAAA0000, port1=0x5555FFFF), RdAddr0=7, BYPASS=1:
   - Same cycle: RdData0=0x5555FFFF.
   - Next cycle: stored value is 0x5555FFFF.
3. BYPASS=0, write x3=0xDEADBEEF, RdAddr0=3:
   - Same cycle: old value 0.
   - Next cycle: 0xDEADBEEF.
4. Write x0=0xFFFFFFFF and IssueEn with IssueRd=0 -> RdData for x0=0, RdBusy=0; debug read of x0 returns 0.
5. IssueEn with IssueRd=9 -> next cycle RdBusy for x9=1. Then IssueRd=9 with WrEn on port0 to x9 in the same cycle -> busy stays 1. Then a WrEn-only write to x9 -> busy 0 next cycle, and with BYPASS=1, RdBusy=0 during the write cycle.
6. Set busy on x4, x8 and x12, then assert Flush together with IssueEn, IssueRd=15 -> next cycle all busy bits 0, including x15.
